// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit buffer.
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GUARD = 2'd1,
        WAIT  = 2'd2
    } tx_drain_state_t;

endpackage

// File: rtl/byte_fifo_ram.sv
// Byte storage for the transmit queue: registered write, combinational read.
module byte_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   we,
    input  logic [AW-1:0]          wr_addr,
    input  logic [UART_BYTE_W-1:0] wr_data,
    input  logic [AW-1:0]          rd_addr,
    output logic [UART_BYTE_W-1:0] rd_data
);

    logic [UART_BYTE_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue feeding UartTx through a start/busy handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [UART_BYTE_W-1:0] push_data,
    output logic                   full,
    output logic                   empty,
    output logic [AW:0]            count,
    output logic                   overflow,
    input  logic                   clear_overflow,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [UART_BYTE_W-1:0] sdata
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic [UART_BYTE_W-1:0] rd_data;
    logic                   do_push;
    logic                   do_pop;
    tx_drain_state_t        state;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = (state == IDLE) && !empty && !tx_busy;

    byte_fifo_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .we      (do_push),
        .wr_addr (wr_ptr),
        .wr_data (push_data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
            // A dropped push outranks a same-cycle clear.
            if (push && full) begin
                overflow <= 1'b1;
            end else if (clear_overflow) begin
                overflow <= 1'b0;
            end
        end
    end

    // GUARD ignores tx_busy for one cycle to cover UartTx busy lag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            tx_start <= 1'b0;
            sdata    <= '0;
        end else begin
            tx_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (do_pop) begin
                        sdata    <= rd_data;
                        tx_start <= 1'b1;
                        state    <= GUARD;
                    end
                end
                GUARD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo against a queue-based reference model.
module tb_uart_tx_fifo;

    logic       clock;
    logic       reset;
    logic       push;
    logic [7:0] push_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       clear_overflow;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] sdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] m_q[$];
    logic [7:0] m_log[$];
    logic [7:0] dut_log[$];
    logic [7:0] in_list[$];
    int         dut_cyc[$];
    bit         m_ovf;
    bit         m_released;
    bit         m_start;
    logic [7:0] m_sdata;
    int         m_last;
    int         cyc = 0;
    int         busy_left = 0;
    int         busy_len = 0;
    bit         force_busy = 0;
    bit         rand_busy = 0;
    int         bad = 0;
    int         max_cnt = 0;

    uart_tx_fifo #(.DEPTH(16)) dut (
        .clock          (clock),
        .reset          (reset),
        .push           (push),
        .push_data      (push_data),
        .full           (full),
        .empty          (empty),
        .count          (count),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .tx_busy        (tx_busy),
        .tx_start       (tx_start),
        .sdata          (sdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_q.delete();
        m_ovf      = 0;
        m_sdata    = 8'h00;
        m_released = 1;
        m_last     = -10;
        m_start    = 0;
        busy_left  = 0;
    endtask

    task automatic clear_logs();
        m_log.delete();
        dut_log.delete();
        dut_cyc.delete();
        in_list.delete();
        bad     = 0;
        max_cnt = 0;
    endtask

    // One clock: drive inputs, advance the model at the edge, log DUT outputs.
    task automatic step(input bit p, input logic [7:0] d, input bit clr);
        int pre;
        bit r;
        bit started;
        push           = p;
        push_data      = d;
        clear_overflow = clr;
        r = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
        tx_busy = force_busy | r | (busy_left > 0 && busy_left <= busy_len);
        @(posedge clock);
        pre     = m_q.size();
        started = 0;
        if (pre > 0 && !tx_busy && m_released) begin
            m_sdata = m_q.pop_front();
            m_log.push_back(m_sdata);
            started    = 1;
            m_released = 0;
            m_last     = cyc;
        end else if (!m_released && cyc >= m_last + 2 && !tx_busy) begin
            m_released = 1;
        end
        if (p && pre == 16) m_ovf = 1;
        else if (clr) m_ovf = 0;
        if (p && pre < 16) m_q.push_back(d);
        if (busy_left > 0) busy_left--;
        if (started) busy_left = busy_len + 1;
        m_start = started;
        cyc++;
        #1;
        if (tx_start === 1'b1) begin
            dut_log.push_back(sdata);
            dut_cyc.push_back(cyc);
        end
        if (tx_start !== m_start || count !== 5'(m_q.size()) ||
            overflow !== m_ovf || sdata !== m_sdata ||
            empty !== (m_q.size() == 0) || full !== (m_q.size() == 16))
            bad++;
        if (int'(count) > max_cnt) max_cnt = int'(count);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1; push = 0; push_data = 0; clear_overflow = 0; tx_busy = 0;
        model_reset();
        #12;
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_count: count=%0d empty=%b full=%b want 0/1/0", count, empty, full);
        end
        checks++;
        if (overflow !== 1'b0 || tx_start !== 1'b0 || sdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_out: ovf=%b start=%b sdata=%h want 0/0/00", overflow, tx_start, sdata);
        end
        reset = 0;
    endtask

    task automatic test_single();
        int c0;
        clear_logs();
        busy_len = 0;
        c0 = cyc;
        step(1'b1, 8'h41, 1'b0);
        idle(6);
        checks++;
        if (dut_log.size() != 1) begin
            errors++;
            $display("FAIL single_n: got %0d pulses want 1", dut_log.size());
        end else begin
            checks++;
            if (dut_cyc[0] != c0 + 2 || dut_log[0] !== 8'h41) begin
                errors++;
                $display("FAIL single_pulse: cycle %0d data %h want %0d 41", dut_cyc[0] - c0, dut_log[0], 2);
            end
        end
        checks++;
        if (count !== 5'd0 || empty !== 1'b1 || bad != 0) begin
            errors++;
            $display("FAIL single_end: count=%0d empty=%b bad=%0d want 0 1 0", count, empty, bad);
        end
    endtask

    task automatic test_burst();
        logic [7:0] exp_b [3];
        exp_b = '{8'h10, 8'h11, 8'h12};
        clear_logs();
        busy_len = 20;
        for (int i = 0; i < 3; i++) step(1'b1, exp_b[i], 1'b0);
        idle(90);
        checks++;
        if (dut_log.size() != 3) begin
            errors++;
            $display("FAIL burst_n: got %0d pulses want 3", dut_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (dut_log[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL burst_data[%0d]: got %h want %h", i, dut_log[i], exp_b[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (dut_cyc[i] - dut_cyc[i-1] != busy_len + 3) begin
                    errors++;
                    $display("FAIL burst_gap[%0d]: got %0d want %0d", i, dut_cyc[i] - dut_cyc[i-1], busy_len + 3);
                end
            end
        end
        checks++;
        if (bad != 0 || count !== 5'd0) begin
            errors++;
            $display("FAIL burst_model: bad=%0d count=%0d want 0 0", bad, count);
        end
    endtask

    task automatic test_full();
        clear_logs();
        force_busy = 1;
        for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_16: full=%b count=%0d ovf=%b want 1 16 0", full, count, overflow);
        end
        step(1'b1, 8'h10, 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL full_17: full=%b count=%0d ovf=%b want 1 16 1", full, count, overflow);
        end
        force_busy = 0;
        busy_len = 1;
        idle(100);
        checks++;
        if (dut_log.size() != 16) begin
            errors++;
            $display("FAIL full_drain_n: got %0d want 16", dut_log.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (dut_log[i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL full_drain[%0d]: got %h want %h", i, dut_log[i], 8'(i));
                end
            end
        end
        checks++;
        if (bad != 0 || overflow !== 1'b1 || empty !== 1'b1) begin
            errors++;
            $display("FAIL full_end: bad=%0d ovf=%b empty=%b want 0 1 1", bad, overflow, empty);
        end
    endtask

    task automatic test_clear_vs_set();
        clear_logs();
        force_busy = 1;
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_plain: ovf=%b want 0", overflow);
        end
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL set_wins: ovf=%b want 1", overflow);
        end
        step(1'b0, 8'h00, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL clr_after: ovf=%b want 0", overflow);
        end
        force_busy = 0;
        busy_len = 0;
        idle(80);
        checks++;
        if (dut_log != m_log || dut_log.size() != 16 || bad != 0) begin
            errors++;
            $display("FAIL clr_drain: got %0d bytes want 16, bad=%0d", dut_log.size(), bad);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] b;
        clear_logs();
        for (int g = 0; g < 8; g++) begin
            busy_len = $urandom_range(0, 2);
            for (int k = 0; k < 5; k++) begin
                b = 8'($urandom);
                in_list.push_back(b);
                step(1'b1, b, 1'b0);
            end
            idle($urandom_range(18, 30));
        end
        idle(120);
        checks++;
        if (dut_log.size() != 40) begin
            errors++;
            $display("FAIL wrap_n: got %0d want 40", dut_log.size());
        end else begin
            for (int i = 0; i < 40; i++) begin
                checks++;
                if (dut_log[i] !== in_list[i]) begin
                    errors++;
                    $display("FAIL wrap_data[%0d]: got %h want %h", i, dut_log[i], in_list[i]);
                end
            end
        end
        checks++;
        if (max_cnt > 16 || overflow !== 1'b0 || bad != 0) begin
            errors++;
            $display("FAIL wrap_end: max=%0d ovf=%b bad=%0d want <=16 0 0", max_cnt, overflow, bad);
        end
    endtask

    task automatic test_random();
        clear_logs();
        rand_busy = 1;
        busy_len = 0;
        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0));
        rand_busy = 0;
        idle(120);
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rand_cycles: %0d cycles differ from model, want 0", bad);
        end
        checks++;
        if (dut_log != m_log) begin
            errors++;
            $display("FAIL rand_stream: got %0d bytes want %0d", dut_log.size(), m_log.size());
        end
    endtask

    task automatic test_reset_mid();
        int  n;
        bool_t: begin end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_clear_vs_set();
        test_wrap();
        test_random();
        test_reset_in_guard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic test_reset_in_guard();
        int  n;
        bit  seen;
        clear_logs();
        force_busy = 1;
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        force_busy = 0;
        busy_len = 3;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1'b0, 8'h00, 1'b0);
            seen = m_start;
        end
        checks++;
        if (!seen || tx_start !== 1'b1) begin
            errors++;
            $display("FAIL rst_setup: start=%b want 1", tx_start);
        end
        reset = 1;
        #1;
        checks++;
        if (tx_start !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
            errors++;
            $display("FAIL rst_async: start=%b count=%0d empty=%b want 0 0 1", tx_start, count, empty);
        end
        model_reset();
        #3;
        reset = 0;
        n = dut_log.size();
        idle(12);
        checks++;
        if (dut_log.size() != n) begin
            errors++;
            $display("FAIL rst_quiet: got %0d pulses want 0", dut_log.size() - n);
        end
        step(1'b1, 8'hA5, 1'b0);
        idle(5);
        checks++;
        if (dut_log.size() != n + 1 || dut_log[dut_log.size()-1] !== 8'hA5) begin
            errors++;
            $display("FAIL rst_resume: got %0d pulses want 1 with a5", dut_log.size() - n);
        end
    endtask

endmodule
